ci_initiator: RTL and testbench

- Issuing side of the custom-instruction (CI) protocol: sequences a single CI transaction onto the ciStart/ciCke/ciN/ciValueA/ciValueB bus and collects ciDone/ciResult from the responders.
- Sits between a request source (bus bridge, debug/test controller) and the CI-attached accelerators, e.g. the microsecond delay element.
- Adds timeout supervision, measures cycles-to-completion and counts stray ciDone pulses.

---
 rtl/ci_pkg.sv | 29 ++
 rtl/ci_initiator_if.sv | 66 ++++++
 rtl/ci_timeout_counter.sv | 54 +++++
 rtl/ci_initiator.sv | 167 ++++++++++++++++
 tb/tb_ci_initiator.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ci_pkg.sv
// ----------------------------------------------------------------------------
// ci_pkg
// Shared definitions for the custom-instruction (CI) initiator:
//   - ci_state_e : FSM state encoding (IDLE / ISSUE / WAIT / RESP)
//   - CI_N_W     : CI identifier width
//   - CI_DATA_W  : operand / result width
//   - STRAY_W, STRAY_MAX : stray-done counter width and saturation value
//   - stray_inc  : saturating increment for the stray-done counter
// ----------------------------------------------------------------------------
package ci_pkg;

    localparam int CI_N_W    = 8;
    localparam int CI_DATA_W = 32;
    localparam int STRAY_W   = 8;

    localparam logic [STRAY_W-1:0] STRAY_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ci_state_e;

    function automatic logic [STRAY_W-1:0] stray_inc(input logic [STRAY_W-1:0] v);
        return (v == STRAY_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ci_initiator_if.sv
// ----------------------------------------------------------------------------
// Interfaces of the CI initiator.
//
// ci_req_if : request/response channel between a request source and the
//             initiator.
//   master (request source): drives reqValid, reqN, reqValueA, reqValueB,
//                            rspReady; observes reqReady and rsp*.
//   slave  (initiator)     : the reverse.
//
// ci_bus_if : CI bus between the initiator and the CI responders.
//   master (initiator): drives ciStart, ciCke, ciN, ciValueA, ciValueB;
//                       observes ciDone, ciResult.
//   slave  (responder): the reverse.
//
// Handshake rule for both valid/ready pairs: a transfer happens on a rising
// clock edge where valid and ready are both 1. A source that raised valid
// keeps valid and its payload unchanged until that edge; ready may be raised
// or dropped at any time and does not depend on valid.
// ----------------------------------------------------------------------------
interface ci_req_if #(parameter int CNT_W = 32);
    import ci_pkg::*;

    logic                 reqValid;
    logic                 reqReady;
    logic [CI_N_W-1:0]    reqN;
    logic [CI_DATA_W-1:0] reqValueA;
    logic [CI_DATA_W-1:0] reqValueB;

    logic                 rspValid;
    logic                 rspReady;
    logic [CI_DATA_W-1:0] rspResult;
    logic                 rspTimeout;
    logic [CNT_W-1:0]     rspCycles;

    modport master (
        output reqValid, reqN, reqValueA, reqValueB, rspReady,
        input  reqReady, rspValid, rspResult, rspTimeout, rspCycles
    );

    modport slave (
        input  reqValid, reqN, reqValueA, reqValueB, rspReady,
        output reqReady, rspValid, rspResult, rspTimeout, rspCycles
    );
endinterface

interface ci_bus_if;
    import ci_pkg::*;

    logic                 ciStart;
    logic                 ciCke;
    logic [CI_N_W-1:0]    ciN;
    logic [CI_DATA_W-1:0] ciValueA;
    logic [CI_DATA_W-1:0] ciValueB;
    logic                 ciDone;
    logic [CI_DATA_W-1:0] ciResult;

    modport master (
        output ciStart, ciCke, ciN, ciValueA, ciValueB,
        input  ciDone, ciResult
    );

    modport slave (
        input  ciStart, ciCke, ciN, ciValueA, ciValueB,
        output ciDone, ciResult
    );
endinterface

// File: rtl/ci_timeout_counter.sv
// ----------------------------------------------------------------------------
// ci_timeout_counter
// Cycle counter shared by latency measurement and timeout supervision.
// 'load' sets the count to 1 (the ciStart cycle is cycle 1); 'enable'
// increments it, saturating at all-ones. The count therefore always equals
// the 1-based index of the current transaction cycle.
// 'expired' is high once the count exceeds LIMIT, i.e. in the WAIT cycle in
// which LIMIT WAIT cycles have elapsed; LIMIT = 0 disables expiry.
//
// Ports:
//   clock, reset : clock, asynchronous active-low reset
//   load         : restart the count at 1
//   enable       : advance the count by one (saturating)
//   count        : current count
//   expired      : timeout reached (never when LIMIT = 0)
// ----------------------------------------------------------------------------
module ci_timeout_counter #(
    parameter int unsigned W     = 32,
    parameter int unsigned LIMIT = 65535
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         expired
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = W'(1);
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (LIMIT != 0) && (count_q > LIMIT_W);

endmodule

// File: rtl/ci_initiator.sv
// ----------------------------------------------------------------------------
// ci_initiator
// Issues one custom-instruction transaction at a time onto the CI bus,
// supervises it with a timeout, measures cycles-to-completion and counts
// ciDone pulses that arrive while no transaction is in flight.
//
// Ports:
//   clock          : system clock, rising edge
//   reset          : asynchronous active-low reset
//   req            : ci_req_if.slave  - request in, response out
//   ci             : ci_bus_if.master - CI bus towards the responders
//   strayDoneCount : saturating count of ciDone seen in IDLE or RESP
//   dbgState       : current FSM state
//
// Flow: IDLE accepts a request and registers it onto ciN/ciValueA/ciValueB;
// ISSUE is the single ciStart cycle; WAIT keeps ciCke high until ciDone or
// timeout; RESP holds the response until rspReady. ciDone on the expiry
// cycle counts as a normal completion.
// ----------------------------------------------------------------------------
module ci_initiator
    import ci_pkg::*;
#(
    parameter int unsigned timeoutCycles  = 65535,
    parameter int unsigned cycleCountBits = 32
) (
    input  logic               clock,
    input  logic               reset,
    ci_req_if.slave            req,
    ci_bus_if.master           ci,
    output logic [STRAY_W-1:0] strayDoneCount,
    output ci_state_e          dbgState
);

    ci_state_e state_q, state_d;

    logic [CI_N_W-1:0]         ci_n_q, ci_n_d;
    logic [CI_DATA_W-1:0]      ci_a_q, ci_a_d;
    logic [CI_DATA_W-1:0]      ci_b_q, ci_b_d;
    logic [CI_DATA_W-1:0]      rsp_result_q, rsp_result_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic [cycleCountBits-1:0] rsp_cycles_q, rsp_cycles_d;
    logic [STRAY_W-1:0]        stray_q, stray_d;

    logic                      cnt_load;
    logic                      cnt_en;
    logic [cycleCountBits-1:0] cnt_value;
    logic                      cnt_expired;

    // One counter serves both purposes: its value is the latency, and it
    // expires once timeoutCycles WAIT cycles have elapsed.
    ci_timeout_counter #(
        .W     (cycleCountBits),
        .LIMIT (timeoutCycles)
    ) u_counter (
        .clock   (clock),
        .reset   (reset),
        .load    (cnt_load),
        .enable  (cnt_en),
        .count   (cnt_value),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d       = state_q;
        ci_n_d        = ci_n_q;
        ci_a_d        = ci_a_q;
        ci_b_d        = ci_b_q;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_cycles_d  = rsp_cycles_q;
        stray_d       = stray_q;
        cnt_load      = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req.reqValid) begin
                    ci_n_d   = req.reqN;
                    ci_a_d   = req.reqValueA;
                    ci_b_d   = req.reqValueB;
                    cnt_load = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_en = 1'b1;
                if (ci.ciDone) begin
                    rsp_result_d  = ci.ciResult;
                    rsp_cycles_d  = cnt_value;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                // ciDone is tested first so it wins on the expiry cycle.
                if (ci.ciDone) begin
                    rsp_result_d  = ci.ciResult;
                    rsp_cycles_d  = cnt_value;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_expired) begin
                    // Count equals timeoutCycles+1 on the expiry cycle.
                    rsp_result_d  = '0;
                    rsp_cycles_d  = cnt_value;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (req.rspReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A done with no transaction in flight carries no data; only count it.
        if (ci.ciDone && ((state_q == ST_IDLE) || (state_q == ST_RESP))) begin
            stray_d = stray_inc(stray_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ci_n_q        <= '0;
            ci_a_q        <= '0;
            ci_b_q        <= '0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_cycles_q  <= '0;
            stray_q       <= '0;
        end else begin
            state_q       <= state_d;
            ci_n_q        <= ci_n_d;
            ci_a_q        <= ci_a_d;
            ci_b_q        <= ci_b_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_cycles_q  <= rsp_cycles_d;
            stray_q       <= stray_d;
        end
    end

    // Strobes decode straight from the state flop so an asynchronous reset
    // drops them immediately.
    assign ci.ciStart = (state_q == ST_ISSUE);
    assign ci.ciCke   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign ci.ciN     = ci_n_q;
    assign ci.ciValueA = ci_a_q;
    assign ci.ciValueB = ci_b_q;

    assign req.reqReady   = (state_q == ST_IDLE);
    assign req.rspValid   = (state_q == ST_RESP);
    assign req.rspResult  = rsp_result_q;
    assign req.rspTimeout = rsp_timeout_q;
    assign req.rspCycles  = rsp_cycles_q;

    assign strayDoneCount = stray_q;
    assign dbgState       = state_q;

endmodule

// File: tb/tb_ci_initiator.sv
// ----------------------------------------------------------------------------
// tb_ci_initiator
// Bench for ci_initiator with timeoutCycles = 10. The clock runs at 2 MHz,
// so a 1 MHz delay-element tick is two clock cycles. Inputs are driven and
// outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ci_initiator;
    import ci_pkg::*;

    localparam int TIMEOUT  = 10;
    localparam int TICK_CYC = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #250 clock = ~clock;

    ci_req_if #(.CNT_W(32)) rq ();
    ci_bus_if               cb ();
    logic [7:0]             stray;
    ci_state_e              dbg_state;

    ci_initiator #(
        .timeoutCycles  (TIMEOUT),
        .cycleCountBits (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (rq),
        .ci             (cb),
        .strayDoneCount (stray),
        .dbgState       (dbg_state)
    );

    int n_cmp     = 0;
    int n_bad     = 0;
    int exp_stray = 0;

    typedef struct {
        logic [7:0]  n;
        logic [31:0] a;
        logic [31:0] b;
        int          delay;     // cycles after the ciStart cycle; -1 = silent
        logic [31:0] res;
        int          hold;      // cycles of response backpressure
        int          stray_at;  // hold cycle carrying a stray ciDone; -1 = none
        logic [31:0] e_res;
        logic        e_to;
        int          e_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the responder finishes in transaction cycle delay+1 (the
    // ciStart cycle is cycle 1). The initiator gives up at cycle TIMEOUT+1;
    // a done on that very cycle still counts as completion.
    function automatic void model(input int delay, input logic [31:0] res,
                                  output logic [31:0] e_res, output logic e_to,
                                  output int e_cyc);
        if (delay >= 0 && (delay + 1) <= (TIMEOUT + 1)) begin
            e_res = res; e_to = 1'b0; e_cyc = delay + 1;
        end else begin
            e_res = '0; e_to = 1'b1; e_cyc = TIMEOUT + 1;
        end
    endfunction

    function automatic int sat_add(input int v, input int k);
        return (v + k > 255) ? 255 : v + k;
    endfunction

    task automatic run_txn(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                           input int delay, input logic [31:0] res, input int hold,
                           input int stray_at, input logic [31:0] e_res, input logic e_to,
                           input int e_cyc);
        int t;
        bit got;
        int starts;
        check("idle_req_ready", rq.reqReady, 1);
        check("idle_no_start", cb.ciStart, 0);
        rq.reqValid = 1'b1; rq.reqN = n; rq.reqValueA = a; rq.reqValueB = b;
        @(negedge clock);
        rq.reqValid = 1'b0; rq.reqN = 8'($urandom); rq.reqValueA = $urandom; rq.reqValueB = $urandom;
        check("issue_ci_n", cb.ciN, n);
        check("issue_ci_a", cb.ciValueA, a);
        check("issue_ci_b", cb.ciValueB, b);
        check("issue_start", cb.ciStart, 1);
        t = 0; got = 0; starts = 0;
        while (!got && t < 40) begin
            if (rq.rspValid) begin
                got = 1;
            end else begin
                if (cb.ciStart) starts++;
                check("busy_cke_ready", {62'b0, cb.ciCke, rq.reqReady}, 64'b10);
                cb.ciDone   = (t == delay);
                cb.ciResult = (t == delay) ? res : $urandom;
                @(negedge clock);
                t++;
            end
        end
        cb.ciDone = 1'b0;
        check("rsp_arrived", got, 1);
        check("single_start", starts, 1);
        check("rsp_timeout", rq.rspTimeout, e_to);
        check("rsp_result", rq.rspResult, e_res);
        check("rsp_cycles", rq.rspCycles, e_cyc);
        check("rsp_cycles_measured", rq.rspCycles, t);
        check("resp_cke_off", cb.ciCke, 0);
        for (int h = 0; h < hold; h++) begin
            // A new request held high must not be taken while responding.
            rq.reqValid = 1'b1; rq.reqN = 8'($urandom);
            cb.ciDone   = (h == stray_at);
            cb.ciResult = $urandom;
            if (h == stray_at) exp_stray = sat_add(exp_stray, 1);
            @(negedge clock);
            cb.ciDone = 1'b0;
            check("hold_valid", rq.rspValid, 1);
            check("hold_result", rq.rspResult, e_res);
            check("hold_timeout", rq.rspTimeout, e_to);
            check("hold_cycles", rq.rspCycles, e_cyc);
            check("hold_not_ready", rq.reqReady, 0);
        end
        rq.rspReady = 1'b1;
        @(negedge clock);
        rq.rspReady = 1'b0;
        check("post_hs_valid", rq.rspValid, 0);
        check("post_hs_ready", rq.reqReady, 1);
        check("post_hs_no_start", cb.ciStart, 0);
        check("stray_count", stray, exp_stray);
        rq.reqValid = 1'b0;
    endtask

    initial begin
        rq.reqValid = 1'b0; rq.reqN = '0; rq.reqValueA = '0; rq.reqValueB = '0;
        rq.rspReady = 1'b0; cb.ciDone = 1'b0; cb.ciResult = '0;

        // Reset state
        @(negedge clock); @(negedge clock);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_req_ready", rq.reqReady, 1);
        check("rst_rsp_valid", rq.rspValid, 0);
        check("rst_rsp_result", rq.rspResult, 0);
        check("rst_rsp_timeout", rq.rspTimeout, 0);
        check("rst_rsp_cycles", rq.rspCycles, 0);
        check("rst_stray", stray, 0);
        check("rst_start_cke", {62'b0, cb.ciStart, cb.ciCke}, 0);
        check("rst_ci_n", cb.ciN, 0);
        check("rst_ci_ab", {cb.ciValueA, cb.ciValueB}, 0);
        reset = 1'b1;
        @(negedge clock);

        // Directed vectors
        vecs[0] = '{8'h05, 32'h1234, 32'h0, 0, 32'hCAFEF00D, 0, -1, 32'hCAFEF00D, 1'b0, 1};
        vecs[1] = '{8'h11, 32'h3, 32'h0, 3 * TICK_CYC, 32'h0000_0003, 0, -1, 32'h0000_0003, 1'b0, 7};
        vecs[2] = '{8'h22, 32'hA5A5, 32'h1, -1, 32'h0, 8, 4, 32'h0, 1'b1, 11};
        vecs[3] = '{8'h33, 32'h77, 32'h88, TIMEOUT, 32'h5A5A0001, 0, -1, 32'h5A5A0001, 1'b0, 11};
        vecs[4] = '{8'h44, 32'h1, 32'h2, 2, 32'hDEADBEEF, 20, -1, 32'hDEADBEEF, 1'b0, 3};
        vecs[5] = '{8'h55, 32'h9, 32'h9, TIMEOUT + 1, 32'h12345678, 0, -1, 32'h0, 1'b1, 11};
        vecs[6] = '{8'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF, TIMEOUT - 1, 32'h0BADC0DE, 1, -1, 32'h0BADC0DE, 1'b0, 10};
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].delay, vecs[i].res, vecs[i].hold,
                    vecs[i].stray_at, vecs[i].e_res, vecs[i].e_to, vecs[i].e_cyc);
        end

        // Stray done in IDLE
        cb.ciDone = 1'b1; cb.ciResult = $urandom;
        exp_stray = sat_add(exp_stray, 1);
        @(negedge clock);
        cb.ciDone = 1'b0;
        @(negedge clock);
        check("idle_stray", stray, exp_stray);
        check("idle_stray_no_start", cb.ciStart, 0);

        // Randomized transactions against the model
        for (int i = 0; i < 30; i++) begin
            int          d, hold, sat;
            logic [31:0] res, e_res;
            logic        e_to;
            int          e_cyc;
            d    = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 13));
            res  = $urandom;
            hold = $urandom_range(0, 3);
            sat  = (hold > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, hold - 1)) : -1;
            model(d, res, e_res, e_to, e_cyc);
            run_txn(8'($urandom), $urandom, $urandom, d, res, hold, sat, e_res, e_to, e_cyc);
        end

        // Reset in the third WAIT cycle
        rq.reqValid = 1'b1; rq.reqN = 8'h77; rq.reqValueA = 32'h1; rq.reqValueB = 32'h2;
        @(negedge clock);
        rq.reqValid = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_wait_cke", cb.ciCke, 1);
        #10 reset = 1'b0;
        #1;
        exp_stray = 0;
        check("async_rst_cke", cb.ciCke, 0);
        check("async_rst_start", cb.ciStart, 0);
        check("async_rst_rsp_valid", rq.rspValid, 0);
        check("async_rst_req_ready", rq.reqReady, 1);
        check("async_rst_stray", stray, exp_stray);
        check("async_rst_ci_n", cb.ciN, 0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            check("after_rst_no_rsp", {62'b0, rq.rspValid, cb.ciCke}, 0);
            check("after_rst_ready", rq.reqReady, 1);
        end

        // Transaction after reset still works
        run_txn(8'h5C, 32'h10, 32'h20, 4, 32'h600DF00D, 2, -1, 32'h600DF00D, 1'b0, 5);

        // Stray counter saturation
        cb.ciDone = 1'b1;
        for (int i = 0; i < 260; i++) begin
            cb.ciResult = $urandom;
            @(negedge clock);
        end
        exp_stray = sat_add(exp_stray, 260);
        cb.ciDone = 1'b0;
        @(negedge clock);
        check("stray_saturated", stray, exp_stray);
        check("stray_sat_idle", rq.reqReady, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
